// File: rtl/alu_pkg.sv
// Shared ALU_32 control encodings and the sequential divider state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq_32.sv
// Restoring shift-subtract 32-bit unsigned divider, one iteration per cycle,
// borrowing an external ALU_32 for the trial subtraction.
module div_seq_32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CntW = $clog2(ITER);

  div_state_e       state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_d, q_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   s;
  logic             borrow;
  logic             ge;

  always_comb begin
    s = {r_q, q_q[WIDTH-1]};
    if (state_q == StRun) begin
      alu_A    = s[WIDTH-1:0];
      alu_B    = d_q;
      alu_ctrl = ALU_SUB;
    end else begin
      alu_A    = '0;
      alu_B    = '0;
      alu_ctrl = ALU_ADD;
    end
    // ALU carry is not an unsigned borrow, so derive it from the sign bits.
    borrow = (~alu_A[WIDTH-1] & alu_B[WIDTH-1]) |
             (~(alu_A[WIDTH-1] ^ alu_B[WIDTH-1]) & alu_result[WIDTH-1]);
    ge  = s[WIDTH] | ~borrow;
    r_d = ge ? alu_result : s[WIDTH-1:0];
    q_d = {q_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor_in == '0) begin
              quotient_out  <= '1;
              remainder_out <= dividend_in;
              div_by_zero   <= 1'b1;
              done          <= 1'b1;
              state_q       <= StDone;
            end else begin
              r_q     <= '0;
              q_q     <= dividend_in;
              d_q     <= divisor_in;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            quotient_out  <= q_d;
            remainder_out <= r_d;
            div_by_zero   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32 with a behavioural ALU_32 on the ALU ports.
module tb_div_seq_32;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend_in, divisor_in;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient_out, remainder_out;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [3:0]  alu_ctrl;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  div_seq_32 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .busy          (busy),
    .done          (done),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_by_zero   (div_by_zero),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result)
  );

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_A & alu_B;
      ALU_OR:  alu_result = alu_A | alu_B;
      ALU_ADD: alu_result = alu_A + alu_B;
      ALU_SUB: alu_result = alu_A - alu_B;
      ALU_SLT: alu_result = {31'd0, $signed(alu_A) < $signed(alu_B)};
      ALU_NOR: alu_result = ~(alu_A | alu_B);
      ALU_EQ:  alu_result = {31'd0, alu_A == alu_B};
      default: alu_result = '0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one divide; optionally re-assert start with other operands at wait cycle inject_at.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inject_at);
    exp_t e;
    int   k;
    int   extra;
    @(negedge clk);
    start       = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    sb.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    dividend_in = $urandom;
    divisor_in  = $urandom;
    k = 0;
    while (!done && k < 100) begin
      check_eq("busy_run", {31'd0, busy}, {31'd0, b != 0});
      check_eq("alu_ctrl_run", {28'd0, alu_ctrl}, {28'd0, (b != 0) ? ALU_SUB : ALU_ADD});
      if (k == inject_at) begin
        start       = 1'b1;
        dividend_in = 32'd50;
        divisor_in  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check_eq("latency", k, (b == 0) ? 32'd0 : 32'd32);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("quotient", quotient_out, e.q);
      check_eq("remainder", remainder_out, e.r);
      check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      check_eq("busy_at_done", {31'd0, busy}, 32'd0);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("single_done", extra, 0);
    check_eq("alu_ctrl_idle", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
  endtask

  initial begin
    int dones;
    rst         = 1'b1;
    start       = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check_eq("rst_quot", quotient_out, 32'd0);
    check_eq("rst_rem", remainder_out, 32'd0);
    check_eq("rst_alu_a", alu_A, 32'd0);
    check_eq("rst_alu_b", alu_B, 32'd0);
    check_eq("rst_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
    @(negedge clk);
    rst = 1'b0;

    run_div(32'd100, 32'd7, -1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_div(32'hFFFF_FFFF, 32'd1, -1);
    run_div(32'd5, 32'd0, -1);
    run_div(32'd7, 32'd9, -1);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, -1);
    run_div(32'd100, 32'd7, 10);

    // Abort a run asynchronously mid-operation.
    @(negedge clk);
    start       = 1'b1;
    dividend_in = 32'd1000;
    divisor_in  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("busy_before_abort", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_quot", quotient_out, 32'd0);
    check_eq("abort_rem", remainder_out, 32'd0);
    check_eq("abort_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check_eq("no_done_after_abort", dones, 0);

    run_div(32'd9, 32'd3, -1);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
